// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants, state encoding and flag-qualification helper
// for alu_sequencer. Define ALU_SEQ_MULTISHIFT_EN to build the SHIFT state that
// iterates the ALU's 1-bit shifts into N-bit shifts.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 32;
  localparam int FSEL_W     = 6;
  localparam int SHAMT_W    = 5;

  // ALU function selects the sequencer treats specially
  localparam logic [FSEL_W-1:0] FS_PASS_S = 6'h00;
  localparam logic [FSEL_W-1:0] FS_PASS_T = 6'h01;
  localparam logic [FSEL_W-1:0] FS_ADD    = 6'h02;
  localparam logic [FSEL_W-1:0] FS_SUB    = 6'h03;
  localparam logic [FSEL_W-1:0] FS_INC    = 6'h04;
  localparam logic [FSEL_W-1:0] FS_DEC    = 6'h05;
  localparam logic [FSEL_W-1:0] FS_SLL    = 6'h0C;
  localparam logic [FSEL_W-1:0] FS_SRL    = 6'h0D;
  localparam logic [FSEL_W-1:0] FS_SRA    = 6'h0E;
  localparam logic [FSEL_W-1:0] FS_ARB_LO = 6'h0F;
  localparam logic [FSEL_W-1:0] FS_ARB_HI = 6'h12;
  localparam logic [FSEL_W-1:0] FS_CHS    = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DONE  = 2'd2
`ifdef ALU_SEQ_MULTISHIFT_EN
   ,ST_SHIFT = 2'd3
`endif
  } seq_state_t;

  function automatic logic is_shift(input logic [FSEL_W-1:0] fsel);
    return (fsel >= FS_SLL) && (fsel <= FS_SRA);
  endfunction

  // {c_ok, v_ok}: which ALU flags are meaningful for this function select
  function automatic logic [1:0] flags_valid(input logic [FSEL_W-1:0] fsel);
    logic arith;
    arith = ((fsel >= FS_ADD) && (fsel <= FS_DEC)) ||
            ((fsel >= FS_ARB_LO) && (fsel <= FS_ARB_HI));
    return {arith || is_shift(fsel), arith};
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-command-at-a-time controller for the shared 32-bit ALU.
// Registers the ALU inputs, optionally iterates 1-bit shifts (macro
// ALU_SEQ_MULTISHIFT_EN), and returns a registered result with sanitised flags.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cmd_ready high; accepted command latched into ALU input regs
// SHIFT | one 1-bit shift per cycle, alu_t <= alu_y (multishift only)
// EXEC  | final ALU pass; result and qualified flags captured
// DONE  | rsp_valid high until rsp_ready
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [FSEL_W-1:0]   cmd_fsel,
  input  logic [DATA_W-1:0]   cmd_s,
  input  logic [DATA_W-1:0]   cmd_t,
  input  logic [SHAMT_W-1:0]  cmd_shamt,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_y,
  output logic                rsp_c,
  output logic                rsp_v,
  output logic [FSEL_W-1:0]   alu_fsel,
  output logic [DATA_W-1:0]   alu_s,
  output logic [DATA_W-1:0]   alu_t,
  input  logic [DATA_W-1:0]   alu_y,
  input  logic                alu_c,
  input  logic                alu_v
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [1:0] flags_ok;

`ifdef ALU_SEQ_MULTISHIFT_EN
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CNT_TWO = SHAMT_W'(2);
  logic [SHAMT_W-1:0] count;
`else
  logic unused_shamt;
  assign unused_shamt = ^cmd_shamt;
`endif

  // reset gates cmd_ready so nothing is offered while the block is held
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign rsp_valid = (state == ST_DONE);
  // alu_fsel already holds PASS_T for a zero-length shift, so its flags mask to 0
  assign flags_ok  = flags_valid(alu_fsel);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = ST_EXEC;
`ifdef ALU_SEQ_MULTISHIFT_EN
          if (is_shift(cmd_fsel) && (cmd_shamt >= CNT_TWO)) state_nxt = ST_SHIFT;
`endif
        end
      end
`ifdef ALU_SEQ_MULTISHIFT_EN
      // leave when count steps down to 1: EXEC performs the last 1-bit shift
      ST_SHIFT: if (count == CNT_TWO) state_nxt = ST_EXEC;
`endif
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU input registers, shift counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_fsel <= FS_PASS_S;
      alu_s    <= '0;
      alu_t    <= '0;
      rsp_y    <= '0;
      rsp_c    <= 1'b0;
      rsp_v    <= 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
      count    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_fsel <= cmd_fsel;
            alu_s    <= cmd_s;
            alu_t    <= cmd_t;
`ifdef ALU_SEQ_MULTISHIFT_EN
            count    <= cmd_shamt;
            // zero-length shift becomes a plain pass of T
            if (is_shift(cmd_fsel) && (cmd_shamt == '0)) alu_fsel <= FS_PASS_T;
`endif
          end
        end
`ifdef ALU_SEQ_MULTISHIFT_EN
        ST_SHIFT: begin
          alu_t <= alu_y;
          count <= count - CNT_ONE;
        end
`endif
        ST_EXEC: begin
          rsp_y <= alu_y;
          rsp_c <= alu_c & flags_ok[1];
          rsp_v <= alu_v & flags_ok[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized commands against a behavioural
// ALU and a result/latency reference model.
module tb_alu_sequencer;

`ifdef ALU_SEQ_MULTISHIFT_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_fsel;
  logic [31:0] cmd_s, cmd_t;
  logic [4:0]  cmd_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_c, rsp_v;
  logic [5:0]  alu_fsel;
  logic [31:0] alu_s, alu_t, alu_y;
  logic        alu_c, alu_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fsel(cmd_fsel),
    .cmd_s(cmd_s), .cmd_t(cmd_t), .cmd_shamt(cmd_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .alu_fsel(alu_fsel), .alu_s(alu_s), .alu_t(alu_t),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v)
  );

  // Behavioural ALU: {y, c, v}. Flags of non-arithmetic ops are driven to 1 as junk.
  function automatic logic [33:0] alu_model(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t);
    logic [31:0] a, b, y;
    logic [32:0] w;
    logic [5:0]  g;
    logic        c, v;
    g = f; a = s; b = t;
    if (f >= 6'h0F && f <= 6'h12) begin g = f - 6'h0D; a = t; b = s; end
    y = s; c = 1'b1; v = 1'b1;
    case (g)
      6'h00: y = s;
      6'h01: y = t;
      6'h02: begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (y[31] != a[31]); end
      6'h03: begin y = a - b; c = (a < b); v = (a[31] != b[31]) && (y[31] != a[31]); end
      6'h04: begin y = a + 1; c = (a == 32'hFFFF_FFFF); v = (a == 32'h7FFF_FFFF); end
      6'h05: begin y = a - 1; c = (a == 32'h0); v = (a == 32'h8000_0000); end
      6'h06: y = s | t;
      6'h07: y = s ^ t;
      6'h08: y = s & t;
      6'h09: y = ~(s | t);
      6'h0A: y = ~s;
      6'h0C: begin y = t << 1; c = t[31]; end
      6'h0D: begin y = t >> 1; c = t[0]; end
      6'h0E: begin y = {t[31], t[31:1]}; c = t[0]; end
      6'h1B: y = -s;
      default: y = (g > 6'h12 && g < 6'h1B) ? s + {t[15:0], t[31:16]} : s;
    endcase
    return {y, c, v};
  endfunction

  always_comb {alu_y, alu_c, alu_v} = alu_model(alu_fsel, alu_s, alu_t);

  // Expected response {y, c, v} straight from the command's meaning
  function automatic logic [33:0] ref_rsp(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t, input logic [4:0] sh);
    logic [33:0] r;
    logic [31:0] y;
    logic        ok;
    int          n;
    if (f >= 6'h0C && f <= 6'h0E) begin
      n = MS ? int'(sh) : 1;
      if (n == 0) return {t, 2'b00};
      if (f == 6'h0C)      return {t << n, t[32-n], 1'b0};
      else if (f == 6'h0D) return {t >> n, t[n-1], 1'b0};
      y = $signed(t) >>> n;
      return {y, t[n-1], 1'b0};
    end
    r  = alu_model(f, s, t);
    ok = (f >= 6'h02 && f <= 6'h05) || (f >= 6'h0F && f <= 6'h12);
    return {r[33:2], r[1] & ok, r[0] & ok};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_fsel  = 6'($urandom);
    cmd_s     = $urandom;
    cmd_t     = $urandom;
    cmd_shamt = 5'($urandom);
  endtask

  // Called at a negedge; leaves the DUT in DONE (response not yet taken)
  task automatic run_cmd(input logic [5:0] f, input logic [31:0] s, input logic [31:0] t,
                         input logic [4:0] sh, input int hold);
    logic [33:0] e;
    int lat, exp_lat, guard;
    e = ref_rsp(f, s, t, sh);
    exp_lat = (MS && f >= 6'h0C && f <= 6'h0E && sh >= 5'd2) ? int'(sh) + 1 : 2;
    cmd_fsel = f; cmd_s = s; cmd_t = t; cmd_shamt = sh; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      guard++;
    end
    chk("accept_in_time", 32'(guard < 10), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    scramble();
    chk("busy_not_ready", 32'(cmd_ready), 32'd0);
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk); scramble();
    end
    chk("latency", lat, exp_lat);
    chk("rsp_y", rsp_y, e[33:2]);
    chk("rsp_c", 32'(rsp_c), 32'(e[1]));
    chk("rsp_v", 32'(rsp_v), 32'(e[0]));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); @(negedge clk); scramble(); end
      chk("hold_y", rsp_y, e[33:2]);
      chk("hold_cv", 32'({rsp_c, rsp_v}), 32'(e[1:0]));
      chk("hold_valid", 32'({rsp_valid, cmd_ready}), 32'b10);
    end
  endtask

  task automatic release_rsp();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [5:0] rf;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_fsel = '0; cmd_s = '0; cmd_t = '0; cmd_shamt = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_cv", 32'({rsp_c, rsp_v}), 32'd0);
    chk("rst_alu_fsel", 32'(alu_fsel), 32'd0);
    chk("rst_alu_s", alu_s, 32'd0);
    chk("rst_alu_t", alu_t, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_out_of_reset", 32'(cmd_ready), 32'd1);

    run_cmd(6'h02, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    chk("add_lit_y", rsp_y, 32'h8000_0000);
    chk("add_lit_v", 32'({rsp_c, rsp_v}), 32'b01);
    release_rsp();
    run_cmd(6'h0C, 32'h1234_5678, 32'h8000_0001, 5'd4, 0);
    release_rsp();
    run_cmd(6'h0E, 32'h0, 32'h8000_0000, 5'd31, 1);
    release_rsp();
    run_cmd(6'h0D, 32'h0, 32'hDEAD_BEEF, 5'd0, 0);
    release_rsp();
    run_cmd(6'h08, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 5);
    chk("and_lit_y", rsp_y, 32'h00F0_00F0);

    // next command offered during the response handshake waits for IDLE
    rsp_ready = 1'b1;
    chk("no_accept_in_done", 32'(cmd_ready), 32'd0);
    run_cmd(6'h03, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);
    release_rsp();

    // reset during a long shift drops the command
    cmd_fsel = 6'h0C; cmd_s = 32'h5; cmd_t = 32'hA5A5_0F0F; cmd_shamt = 5'd10; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'({rsp_valid, cmd_ready}), 32'd0);
    chk("midrst_alu_fsel", 32'(alu_fsel), 32'd0);
    chk("midrst_alu_t", alu_t, 32'd0);
    chk("midrst_alu_s", alu_s, 32'd0);
    chk("midrst_rsp_y", rsp_y, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("no_rsp_after_reset", seen, 0);
    run_cmd(6'h0C, 32'h0, 32'h0000_0F01, 5'd3, 0);
    release_rsp();

    run_cmd(6'h0D, 32'h0, 32'h0000_0003, 5'd8, 0);
    release_rsp();
    run_cmd(6'h2A, 32'hCAFE_F00D, 32'h1111_2222, 5'd7, 0);
    release_rsp();
    run_cmd(6'h1B, 32'h0000_0001, 32'h0, 5'd0, 0);
    release_rsp();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) rf = 6'h0C + 6'($urandom_range(0, 2));
      else                           rf = 6'($urandom_range(0, 63));
      run_cmd(rf, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
      release_rsp();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
